// File: rtl/rcservo_sequencer.sv
// rcservo_sequencer: multi-channel RC servo pulse sequencer.
// Each frame starts with a one-cycle LOAD that samples the commands, clamps
// them to +/-500 us around centre and slews the applied positions. The
// channels then get back-to-back slots, each with one pulse of 1000..2000 us.
// The FSM idles until the frame counter wraps.
//
// state | meaning
// LOAD  | frame start: sample commands, update positions, pulse frame_sync
// SLOT  | channel ch_q owns the current slot; its pulse is generated here
// IDLE  | all slots done, wait for the frame counter to wrap
module rcservo_sequencer #(
  parameter int CHANNELS = 4,
  parameter int CLK_FREQ = 48000000,
  parameter int FRAME_US = 20000,
  parameter int SLOT_US  = 2500,
  parameter int MAX_STEP = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     enable,
  input  logic [32*CHANNELS-1:0]  jointFreqCmd,
  output logic [32*CHANNELS-1:0]  jointFeedback,
  output logic [CHANNELS-1:0]     PWM,
  output logic                    frame_sync
);

  localparam int TICKS_US    = CLK_FREQ / 1000000;
  localparam int FRAME_TICKS = FRAME_US * TICKS_US;
  localparam int SLOT_TICKS  = SLOT_US * TICKS_US;
  localparam int FCNT_W      = $clog2(FRAME_TICKS);
  localparam int SCNT_W      = $clog2(SLOT_TICKS);
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {LOAD, SLOT, IDLE} state_t;

  state_t              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                en_lat_q, en_lat_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic signed [11:0]  pos_q [CHANNELS];
  logic signed [11:0]  pos_d [CHANNELS];

  // Free-running frame counter; the frame length never depends on the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FCNT_W'(FRAME_TICKS - 1)) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FCNT_W'(1);
    end
  end

  // Target clamp and slew limit, applied only in LOAD. The 32-bit compare
  // keeps extreme commands safe; the difference is formed in int width.
  always_comb begin : p_pos
    logic signed [31:0] cmd;
    logic signed [11:0] tgt;
    int                 diff;
    int                 step;
    int                 nxt;
    for (int k = 0; k < CHANNELS; k++) begin
      cmd = signed'(jointFreqCmd[32*k +: 32]);
      if (cmd > 500) begin
        tgt = 12'sd500;
      end else if (cmd < -500) begin
        tgt = -12'sd500;
      end else begin
        tgt = cmd[11:0];
      end
      diff = int'(tgt) - int'(pos_q[k]);
      if (MAX_STEP == 0) begin
        step = diff;
      end else if (diff > MAX_STEP) begin
        step = MAX_STEP;
      end else if (diff < -MAX_STEP) begin
        step = -MAX_STEP;
      end else begin
        step = diff;
      end
      nxt = int'(pos_q[k]) + step;
      pos_d[k] = (state_q == LOAD) ? nxt[11:0] : pos_q[k];
    end
  end

  // Applied position registers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (reset) begin
        pos_q[k] <= '0;
      end else begin
        pos_q[k] <= pos_d[k];
      end
    end
  end

  // Next-state and pulse logic. Enable is latched at scnt==0 so mid-slot
  // changes can neither cut a pulse short nor start one late.
  always_comb begin : p_fsm
    logic active;
    int   w_ticks;
    state_d  = state_q;
    ch_d     = ch_q;
    scnt_d   = scnt_q;
    en_lat_d = en_lat_q;
    pwm_d    = '0;
    active   = 1'b0;
    w_ticks  = (1500 + int'(pos_q[ch_q])) * TICKS_US;
    case (state_q)
      LOAD: begin
        state_d = SLOT;
        ch_d    = '0;
        scnt_d  = '0;
      end
      SLOT: begin
        active   = (scnt_q == '0) ? enable[ch_q] : en_lat_q;
        en_lat_d = active;
        if (active && (int'(scnt_q) < w_ticks)) begin
          pwm_d[ch_q] = 1'b1;
        end
        if (scnt_q == SCNT_W'(SLOT_TICKS - 1)) begin
          scnt_d = '0;
          if (ch_q == CH_W'(CHANNELS - 1)) begin
            state_d = IDLE;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end
      IDLE: begin
        if (fcnt_q == FCNT_W'(FRAME_TICKS - 1)) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // FSM and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      ch_q     <= '0;
      scnt_q   <= '0;
      en_lat_q <= 1'b0;
      pwm_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      scnt_q   <= scnt_d;
      en_lat_q <= en_lat_d;
      pwm_q    <= pwm_d;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_fb
    assign jointFeedback[32*k +: 32] = 32'(pos_q[k]);
  end

  assign PWM        = pwm_q;
  assign frame_sync = (state_q == LOAD) && !reset;

endmodule
